// File: rtl/team_08_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter, whole-cycle grants.
// Optional watchdog abort built when TEAM_08_ARB_TIMEOUT_EN is defined.
module team_08_wb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
`ifdef TEAM_08_ARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  state_t state_q, state_d;
  // last_q: 0 = m0 last owned the bus, 1 = m1
  logic   last_q, last_d;
  logic   wd_fire;

`ifdef TEAM_08_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        stalled;

  // owner holds a strobe the slave has not acked
  always_comb begin
    stalled = 1'b0;
    if (state_q == GNT0)
      stalled = m0_cyc_i && m0_stb_i && !s_ack_i;
    else if (state_q == GNT1)
      stalled = m1_cyc_i && m1_stb_i && !s_ack_i;
    wd_fire = stalled && (cnt_q == 16'(TIMEOUT - 1));
    cnt_d   = (stalled && !wd_fire) ? cnt_q + 16'd1 : 16'd0;
  end

  // watchdog counter register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_fire = 1'b0;
`endif

  // state and round-robin history register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // arbitration and release decisions
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) state_d = IDLE;
`ifdef TEAM_08_ARB_TIMEOUT_EN
        else if (wd_fire) state_d = ABORT;
`endif
      end
      GNT1: begin
        if (!m1_cyc_i) state_d = IDLE;
`ifdef TEAM_08_ARB_TIMEOUT_EN
        else if (wd_fire) state_d = ABORT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // bus steering for the current owner
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    unique case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
`ifdef TEAM_08_ARB_TIMEOUT_EN
      ABORT: begin
        m0_err_o = ~last_q;
        m1_err_o = last_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_team_08_wb_arbiter.sv
// Bench for team_08_wb_arbiter: directed plan plus random traffic
// checked against an owner/round-robin reference model.
module tb_team_08_wb_arbiter;

  localparam int TO = 8;
`ifdef TEAM_08_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c0, s0, w0, c1, s1, w1;
  logic [3:0]  sel0, sel1;
  logic [31:0] adr0, adr1, dat0, dat1;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] sdat;
  logic        sack;
  logic [1:0]  grant_o;

  team_08_wb_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0),
    .m0_sel_i(sel0), .m0_adr_i(adr0), .m0_dat_i(dat0),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1),
    .m1_sel_i(sel1), .m1_adr_i(adr1), .m1_dat_i(dat1),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(sdat), .s_ack_i(sack), .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_err = 0;

  // reference model: owner -1 none, 0/1 master; abt = aborted master or -1
  int owner = -1;
  int last = 1;
  int stall = 0;
  int abt = -1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    logic [1:0]  eg;
    logic [6:0]  ectl;
    logic [31:0] eadr, edat;
    logic [1:0]  e0, e1;
    logic [31:0] ed0, ed1;
    eg = 2'b00; ectl = '0; eadr = '0; edat = '0;
    e0 = '0; e1 = '0; ed0 = '0; ed1 = '0;
    if (owner == 0) begin
      eg = 2'b01; ectl = {c0, s0, w0, sel0}; eadr = adr0; edat = dat0;
      e0 = {sack, 1'b0}; ed0 = sdat;
    end else if (owner == 1) begin
      eg = 2'b10; ectl = {c1, s1, w1, sel1}; eadr = adr1; edat = dat1;
      e1 = {sack, 1'b0}; ed1 = sdat;
    end
    if (abt == 0) e0[0] = 1'b1;
    if (abt == 1) e1[0] = 1'b1;
    chk("grant", 64'(grant_o), 64'(eg));
    chk("sctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(ectl));
    chk("sadr", 64'(s_adr_o), 64'(eadr));
    chk("sdat", 64'(s_dat_o), 64'(edat));
    chk("m0ae", 64'({m0_ack_o, m0_err_o}), 64'(e0));
    chk("m0dat", 64'(m0_dat_o), 64'(ed0));
    chk("m1ae", 64'({m1_ack_o, m1_err_o}), 64'(e1));
    chk("m1dat", 64'(m1_dat_o), 64'(ed1));
  endtask

  task automatic model_step();
    logic [1:0] cyc, stb;
    cyc = {c1, c0};
    stb = {s1, s0};
    if (rst) begin
      owner = -1; last = 1; stall = 0; abt = -1;
    end else if (abt >= 0) begin
      abt = -1;
    end else if (owner < 0) begin
      if (cyc == 2'b11) owner = 1 - last;
      else if (cyc[0]) owner = 0;
      else if (cyc[1]) owner = 1;
      if (owner >= 0) last = owner;
    end else if (!cyc[owner]) begin
      owner = -1; stall = 0;
    end else if (WD && stb[owner] && !sack) begin
      if (stall == TO - 1) begin
        abt = owner; owner = -1; stall = 0;
      end else begin
        stall++;
      end
    end else begin
      stall = 0;
    end
  endtask

  // check mid-cycle, advance one edge, update model
  task automatic cycle();
    #3;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    c0 = 0; s0 = 0; w0 = 0; sel0 = '0; adr0 = '0; dat0 = '0;
    c1 = 0; s1 = 0; w1 = 0; sel1 = '0; adr1 = '0; dat1 = '0;
    sack = 0; sdat = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    model_step();
    #1;
    do_reset();
    #3;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_scyc", 64'(s_cyc_o), 64'd0);

    // lone m0 read
    c0 = 1; s0 = 1; sel0 = 4'hF; adr0 = 32'h3000_0004;
    dat1 = 32'h1111_2222; sdat = 32'h5555_AAAA;
    cycle();
    chk("lone_grant", 64'(grant_o), 64'h1);
    chk("lone_adr", 64'(s_adr_o), 64'h3000_0004);
    cycle();
    sack = 1; sdat = 32'hDEAD_BEEF;
    #1;
    chk("lone_ack", 64'(m0_ack_o), 64'h1);
    chk("lone_dat", 64'(m0_dat_o), 64'hDEAD_BEEF);
    chk("lone_m1ack", 64'(m1_ack_o), 64'h0);
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // contention out of reset
    do_reset();
    c0 = 1; s0 = 1; c1 = 1; s1 = 1; adr1 = 32'h40;
    cycle();
    chk("cont_first", 64'(grant_o), 64'h1);
    c0 = 0; s0 = 0;
    cycle();
    chk("cont_gap", 64'(grant_o), 64'h0);
    cycle();
    chk("cont_second", 64'(grant_o), 64'h2);
    c1 = 0; s1 = 0; c0 = 1; s0 = 1;
    cycle();
    c1 = 1; s1 = 1;
    cycle();
    chk("cont_alt", 64'(grant_o), 64'h1);
    idle_inputs();
    cycle();

    // hold-off during m1 burst
    c1 = 1; s1 = 1; w1 = 1; sel1 = 4'h3;
    cycle();
    c0 = 1; s0 = 1;
    for (int i = 0; i < 4; i++) begin
      sack = 1; adr1 = 32'h100 + 32'(i * 4); dat1 = $urandom;
      #1;
      chk("hold_m0ack", 64'(m0_ack_o), 64'h0);
      chk("hold_grant", 64'(grant_o), 64'h2);
      cycle();
    end
    sack = 0; c1 = 0; s1 = 0;
    cycle();
    cycle();
    chk("hold_m0gnt", 64'(grant_o), 64'h1);
    idle_inputs();
    cycle();

    // stalled m1 strobe
    do_reset();
    c1 = 1; s1 = 1; adr1 = 32'h3000_0010;
    cycle();
    if (WD) begin
      for (int i = 0; i < TO; i++) begin
        chk("wd_hold", 64'({grant_o, m1_err_o}), 64'b100);
        cycle();
      end
      chk("wd_err", 64'(m1_err_o), 64'h1);
      chk("wd_m0err", 64'(m0_err_o), 64'h0);
      chk("wd_scyc", 64'(s_cyc_o), 64'h0);
      cycle();
      chk("wd_idle", 64'({grant_o, m1_err_o}), 64'h0);
      cycle();
    end else begin
      for (int i = 0; i < 1000; i++) begin
        chk("nowd", 64'({grant_o, m0_err_o, m1_err_o}), 64'b1000);
        cycle();
      end
    end
    idle_inputs();
    cycle();
    cycle();

    // reset during m0 stalled read
    c0 = 1; s0 = 1; adr0 = 32'h3000_0020;
    cycle();
    cycle();
    cycle();
    rst = 1;
    cycle();
    chk("mrst_scyc", 64'(s_cyc_o), 64'h0);
    chk("mrst_grant", 64'(grant_o), 64'h0);
    chk("mrst_ae", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'h0);
    rst = 0;
    c1 = 1; s1 = 1;
    cycle();
    chk("mrst_win", 64'(grant_o), 64'h1);
    idle_inputs();
    cycle();
    cycle();

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (c0) c0 = ($urandom_range(5) != 0);
      else    c0 = ($urandom_range(2) == 0);
      if (c1) c1 = ($urandom_range(5) != 0);
      else    c1 = ($urandom_range(2) == 0);
      s0 = c0 && ($urandom_range(3) != 0);
      s1 = c1 && ($urandom_range(3) != 0);
      w0 = 1'($urandom); w1 = 1'($urandom);
      sel0 = 4'($urandom); sel1 = 4'($urandom);
      adr0 = $urandom; adr1 = $urandom;
      dat0 = $urandom; dat1 = $urandom;
      sack = ($urandom_range(3) == 0);
      sdat = $urandom;
      if (i == 400) rst = 1;
      cycle();
      rst = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/team_08_wb_arbiter.md
# team_08_wb_arbiter

Two-master Wishbone arbiter that shares the single team_08_WB slave port between the management-core Wishbone master (wbs_* from the user-project wrapper) and a secondary debug master driven from the logic-analyzer bridge. It sits between the wrapper's Wishbone pins and team_08_WB. It grants whole bus cycles (cyc-to-cyc) round-robin. An optional watchdog aborts a stalled cycle with an error pulse.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-select width is DATA_W/8
- TIMEOUT, 255, stalled-cycle limit in clocks (1..65535); used only with the watchdog compiled in

Ports (mN = m0, m1; m0 = management core, m1 = LA debug master):
- wb_clk_i  input  1  single clock; all state on rising edge
- wb_rst_i  input  1  reset, synchronous, active-high
- mN_cyc_i  input  1  master N bus cycle request
- mN_stb_i  input  1  master N strobe
- mN_we_i  input  1  master N write enable
- mN_sel_i  input  DATA_W/8  master N byte selects
- mN_adr_i  input  ADDR_W  master N address
- mN_dat_i  input  DATA_W  master N write data
- mN_dat_o  output  DATA_W  read data to master N
- mN_ack_o  output  1  ack to master N
- mN_err_o  output  1  error (timeout abort) to master N
- s_cyc_o, s_stb_o, s_we_o  output  1  to slave
- s_sel_o  output  DATA_W/8  to slave
- s_adr_o  output  ADDR_W  to slave
- s_dat_o  output  DATA_W  write data to slave
- s_dat_i  input  DATA_W  read data from slave
- s_ack_i  input  1  ack from slave
- grant_o  output  2  one-hot owner: 01 = m0, 10 = m1, 00 = none

## Operation
- States: IDLE, GNT0, GNT1, ABORT (ABORT exists only with the watchdog).
- IDLE: if exactly one mN_cyc_i is high, go to GNTN next cycle. If both are high, grant the master not recorded in last_grant. Record the granted master in last_grant.
- GNTN: s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i. s_we/sel/adr/dat are muxed from master N. mN_ack_o = s_ack_i and mN_dat_o = s_dat_i, combinationally.
- Non-owner: ack_o = 0, err_o = 0, dat_o = 0.
- In IDLE, all s_* outputs are 0.
- GNTN to IDLE on the cycle after mN_cyc_i is sampled low. This leaves one idle cycle between owners.
- Grant is never revoked while the owner holds cyc, except by a watchdog abort.
- Owner dropping cyc in the same cycle as s_ack_i: the ack is still forwarded. Release follows next cycle.
- Pipelined/burst transfers pass through unchanged while the owner holds cyc.

## Timing
- Reset (synchronous, wb_rst_i high at an edge) sets:
  - state = IDLE, last_grant = m1 (so m0 wins the first contention), watchdog counter = 0
  - all outputs 0, including grant_o = 00
- Reset mid-cycle: the bus drops at the next edge and s_cyc_o = 0. No ack or err is generated.
- Grant latency: cyc_i sampled high in IDLE gives s_cyc_o high 1 cycle later. Data path through the arbiter adds 0 cycles.
- Back-to-back contention alternates owners. Each owner loses 1 idle cycle per handover.
- Watchdog counter:
  - counts clocks in GNTN with mN_stb_i = 1 and s_ack_i = 0
  - clears on any s_ack_i, on stb low, and on leaving GNTN
  - when counter == TIMEOUT-1 while stalled, the next state is ABORT
- ABORT lasts exactly 1 cycle: s_cyc_o = s_stb_o = 0, mN_err_o = 1 for the aborted owner only. Then IDLE.
- An owner still asserting cyc after an abort re-arbitrates normally; round-robin favours the other master.

## Configuration
- TEAM_08_ARB_TIMEOUT_EN defined: watchdog counter, ABORT state and err pulses are built. The counter width is 16 bits.
- TEAM_08_ARB_TIMEOUT_EN undefined: no counter and no ABORT state. m0_err_o and m1_err_o are tied 0, TIMEOUT is ignored, and a stalled slave holds the bus indefinitely.

## Test plan
- Reset then lone request: m0 cyc/stb, read adr 0x3000_0004, slave acks 2 cycles later with 0xDEADBEEF. Required: grant_o = 01 one cycle after request, m0_dat_o = 0xDEADBEEF with m0_ack_o, m1_ack_o = 0.
- Simultaneous request out of reset: both cyc high. Required:
  - m0 granted first
  - after m0 drops cyc: 1 idle cycle, then grant_o = 10
  - next simultaneous request goes to m0 again (alternation)
- Hold-off: m1 owns the bus and issues a 4-beat burst while m0 requests. Required: m0 sees no ack and grant_o stays 10 until m1 drops cyc.
- Watchdog (macro defined, TIMEOUT = 8): m1 strobes and the slave never acks. Required:
  - ABORT after 8 stalled cycles
  - m1_err_o = 1 for exactly one cycle, s_cyc_o = 0 in that cycle
  - IDLE follows
- Watchdog off (macro undefined): same stimulus for 1000 cycles. Required: grant_o stays 10 and err outputs stay 0.
- Reset mid-transfer: assert wb_rst_i during m0's stalled read. Required: next edge s_cyc_o = 0, grant_o = 00, no ack or err, and m0 wins the next contention.
